ecg_trace_renderer: RTL and testbench

//   Multi-channel scrolling ECG trace renderer for the VGA pixel pipeline. Accepts

---
 rtl/ecg_trace_renderer.sv | 133 +++++++++++++
 tb/tb_ecg_trace_renderer.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/ecg_trace_renderer.sv
// ecg_trace_renderer: multi-channel scrolling ECG trace renderer for the VGA pixel pipeline.
// Samples arrive on a valid/ready stream and are stored in one circular buffer per channel.
// Each channel is drawn as a continuous trace in its own horizontal band of the screen.
// Vertical segments join neighbouring columns, and the line half-thickness is THICK rows.
// Ports:
//   clk, reset      pixel clock; synchronous active-high reset
//   s_valid/s_ready sample stream handshake (s_ready low in reset or while frozen)
//   s_ch, s_data    target channel and unsigned sample (0 = bottom of band)
//   freeze          hold the displayed window and stall the input stream
//   x, y            current pixel column / row
//   draw            per-channel trace hit for the pixel presented two cycles earlier
//   fill            per-channel count of valid columns, packed FW bits per channel
module ecg_trace_renderer #(
    parameter int NUM_CH   = 2,
    parameter int SAMPLE_W = 8,
    parameter int DEPTH    = 1024,
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int THICK    = 1,
    localparam int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int FW      = $clog2(H_ACTIVE + 1)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 s_valid,
    output logic                 s_ready,
    input  logic [CH_W-1:0]      s_ch,
    input  logic [SAMPLE_W-1:0]  s_data,
    input  logic                 freeze,
    input  logic [9:0]           x,
    input  logic [9:0]           y,
    output logic [NUM_CH-1:0]    draw,
    output logic [NUM_CH*FW-1:0] fill
);
    localparam int AW   = $clog2(DEPTH);
    localparam int BAND = V_ACTIVE / NUM_CH;
    localparam int PW   = SAMPLE_W + 10;

    logic       accept;
    logic       latch;
    logic [9:0] x1;
    logic [9:0] y1;

    assign s_ready = ~reset & ~freeze;
    assign accept  = s_valid & s_ready;
    assign latch   = (x == 10'd0) && (y == 10'd0) && ~freeze;

    always_ff @(posedge clk) begin
        if (reset) begin
            x1 <= 10'd0;
            y1 <= 10'd0;
        end else begin
            x1 <= x;
            y1 <= y;
        end
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        localparam logic [11:0] TOP = 12'(c * BAND);
        localparam logic [11:0] BOT = 12'(c * BAND + BAND - 1);

        logic [SAMPLE_W-1:0] mem [DEPTH];
        logic [SAMPLE_W-1:0] rd_data;
        logic [AW-1:0]       wr_ptr;
        logic [AW-1:0]       base;
        logic [AW-1:0]       next_base;
        logic [AW-1:0]       rd_addr;
        logic [FW-1:0]       fill_cnt;
        logic [FW-1:0]       fill_lat;
        logic [PW-1:0]       prod;
        logic [11:0]         cur_y;
        logic [11:0]         prev_y;
        logic [11:0]         prev_sel;
        logic [11:0]         lo_raw;
        logic [11:0]         hi_raw;
        logic [11:0]         lo;
        logic [11:0]         hi;
        logic                we;
        logic                col_v;
        logic                prev_v;
        logic                hit;

        assign we        = accept && (s_ch == CH_W'(c));
        assign next_base = wr_ptr - AW'(H_ACTIVE);
        // On the latch cycle pixel (0,0) must already use the new window.
        assign rd_addr   = (latch ? next_base : base) + AW'(x);

        always_ff @(posedge clk) begin
            if (we) mem[wr_ptr] <= s_data;
            rd_data <= mem[rd_addr];
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                wr_ptr   <= '0;
                base     <= '0;
                fill_cnt <= '0;
                fill_lat <= '0;
                prev_y   <= '0;
                prev_v   <= 1'b0;
                hit      <= 1'b0;
            end else begin
                if (we) begin
                    wr_ptr   <= wr_ptr + 1'b1;
                    fill_cnt <= (fill_cnt == FW'(H_ACTIVE)) ? fill_cnt : fill_cnt + 1'b1;
                end
                if (latch) begin
                    base     <= next_base;
                    fill_lat <= fill_cnt;
                end
                prev_y <= cur_y;
                prev_v <= col_v;
                hit    <= col_v && (y1 < 10'(V_ACTIVE)) && (12'(y1) >= lo) && (12'(y1) <= hi);
            end
        end

        always_comb begin
            prod     = PW'(rd_data) * PW'(BAND);
            cur_y    = BOT - 12'(prod >> SAMPLE_W);
            // Column x is valid when x >= H_ACTIVE - fill; rearranged to avoid a subtraction.
            col_v    = (x1 < 10'(H_ACTIVE)) && ((11'(x1) + 11'(fill_lat)) >= 11'(H_ACTIVE));
            // Left edge of a row or of the valid region has no neighbour: draw a dot.
            prev_sel = (x1 != 10'd0 && prev_v) ? prev_y : cur_y;
            lo_raw   = (prev_sel < cur_y) ? prev_sel : cur_y;
            hi_raw   = (prev_sel < cur_y) ? cur_y : prev_sel;
            lo       = (lo_raw < TOP + 12'(THICK)) ? TOP : lo_raw - 12'(THICK);
            hi       = (hi_raw + 12'(THICK) > BOT) ? BOT : hi_raw + 12'(THICK);
        end

        assign draw[c]            = hit;
        assign fill[c*FW +: FW]   = fill_cnt;
    end
endmodule

// File: tb/tb_ecg_trace_renderer.sv
// tb_ecg_trace_renderer: directed checks of the ECG trace renderer with two channels (band = 240 rows).
module tb_ecg_trace_renderer;
    localparam int H = 640;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [0:0]  s_ch = 1'b0;
    logic [7:0]  s_data = 8'd0;
    logic        freeze = 1'b0;
    logic [9:0]  x = 10'd700;
    logic [9:0]  y = 10'd500;
    logic [1:0]  draw;
    logic [19:0] fill;

    int n_cmp = 0;
    int n_bad = 0;
    int c299 = 0;
    int c300 = 0;
    int c301 = 0;
    logic [1:0] seen [H];

    always #5 clk = ~clk;

    ecg_trace_renderer dut (
        .clk(clk), .reset(reset), .s_valid(s_valid), .s_ready(s_ready), .s_ch(s_ch),
        .s_data(s_data), .freeze(freeze), .x(x), .y(y), .draw(draw), .fill(fill)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int got, input int want);
        n_cmp++;
        if (got != want) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, want);
        end
    endtask

    task automatic push(input int ch, input int val, input int n);
        for (int i = 0; i < n; i++) begin
            s_valid = 1'b1;
            s_ch    = 1'(ch);
            s_data  = 8'(val);
            tick;
        end
        s_valid = 1'b0;
    endtask

    task automatic frame;
        x = 10'd0;
        y = 10'd0;
        tick;
        x = 10'd700;
        y = 10'd500;
    endtask

    // Present columns xa..xb of one row; draw for column k is recorded one step after it is presented
    // plus one pipeline cycle, i.e. two clock edges later.
    task automatic scan(input int row, input int xa, input int xb);
        y = 10'(row);
        for (int k = xa; k <= xb + 1; k++) begin
            x = 10'(k);
            tick;
            if (k > xa) seen[k-1] = draw;
        end
        x = 10'd700;
        y = 10'd500;
    endtask

    function automatic int cnt(input int ch, input int a, input int b);
        int n = 0;
        for (int i = a; i <= b; i++) n += int'(seen[i][ch]);
        return n;
    endfunction

    initial begin
        repeat (3) tick;
        chk("rst_ready", int'(s_ready), 0);
        chk("rst_draw", int'(draw), 0);
        chk("rst_fill", int'(fill), 0);
        reset = 1'b0;
        tick;
        chk("ready", int'(s_ready), 1);

        // 100 samples of 128 on ch0: yv = 239 - 120 = 119, rows 118..120, right-aligned.
        push(0, 128, 100);
        chk("fill0_100", int'(fill[9:0]), 100);
        chk("fill1_0", int'(fill[19:10]), 0);
        frame;
        scan(119, 0, H - 1);
        chk("part_left", cnt(0, 0, 539), 0);
        chk("part_right", cnt(0, 540, 639), 100);
        chk("part_ch1", cnt(1, 0, 639), 0);
        scan(121, 0, H - 1);
        chk("part_r121", cnt(0, 0, 639), 0);

        // ch0 window: 100x128, 200x0, 340x255; ch1: 640x255 (rows 240..241).
        push(0, 0, 200);
        push(0, 255, 340);
        push(1, 255, 640);
        chk("fill0_sat", int'(fill[9:0]), 640);
        frame;
        scan(119, 0, H - 1);
        chk("r119_a", cnt(0, 0, 99), 100);
        chk("r119_c100", cnt(0, 100, 100), 1);
        chk("r119_b", cnt(0, 101, 299), 0);
        chk("r119_c300", cnt(0, 300, 300), 1);
        chk("r119_c", cnt(0, 301, 639), 0);
        chk("r119_ch1", cnt(1, 0, 639), 0);
        scan(239, 0, H - 1);
        chk("r239_a", cnt(0, 0, 99), 0);
        chk("r239_b", cnt(0, 100, 300), 201);
        chk("r239_c", cnt(0, 301, 639), 0);
        chk("r239_ch1", cnt(1, 0, 639), 0);
        scan(240, 0, H - 1);
        chk("r240_ch0", cnt(0, 0, 639), 0);
        chk("r240_ch1", cnt(1, 0, 639), 640);
        scan(241, 0, H - 1);
        chk("r241_ch1", cnt(1, 0, 639), 640);
        scan(242, 0, H - 1);
        chk("r242_ch1", cnt(1, 0, 639), 0);
        scan(1, 0, H - 1);
        chk("r1_left", cnt(0, 0, 299), 0);
        chk("r1_right", cnt(0, 300, 639), 340);
        scan(479, 0, H - 1);
        chk("r479_ch1", cnt(1, 0, 639), 0);

        // Step 0 -> 255 at column 300 must be drawn as an unbroken vertical segment.
        for (int r = 0; r < 240; r++) begin
            scan(r, 298, 301);
            c299 += int'(seen[299][0]);
            c300 += int'(seen[300][0]);
            c301 += int'(seen[301][0]);
        end
        chk("gap_c299", c299, 2);
        chk("gap_c300", c300, 240);
        chk("gap_c301", c301, 2);

        // Latency: pixel (50,119) shows up after two edges, not one.
        y = 10'd121;
        x = 10'd50;
        tick;
        tick;
        y = 10'd119;
        tick;
        chk("lat1", int'(draw[0]), 0);
        tick;
        chk("lat2", int'(draw[0]), 1);

        // Freeze: new ch1 data written beforehand must stay hidden while frozen.
        push(1, 0, 320);
        freeze = 1'b1;
        tick;
        chk("frz_ready", int'(s_ready), 0);
        push(1, 128, 5);
        frame;
        scan(240, 0, H - 1);
        chk("frz_f1", cnt(1, 0, 639), 640);
        frame;
        scan(240, 0, H - 1);
        chk("frz_f2", cnt(1, 0, 639), 640);
        scan(479, 0, H - 1);
        chk("frz_r479", cnt(1, 0, 639), 0);
        freeze = 1'b0;
        tick;
        chk("unfrz_ready", int'(s_ready), 1);
        scan(240, 0, H - 1);
        chk("unfrz_nolatch", cnt(1, 0, 639), 640);
        frame;
        scan(240, 0, H - 1);
        chk("unfrz_r240", cnt(1, 0, 639), 321);
        scan(479, 0, H - 1);
        chk("unfrz_r479", cnt(1, 0, 639), 320);
        scan(359, 0, H - 1);
        chk("unfrz_stall", cnt(1, 321, 639), 0);

        // Reset in the middle of a drawn row.
        y = 10'd240;
        x = 10'd4;
        tick;
        x = 10'd5;
        tick;
        chk("pre_rst", int'(draw[1]), 1);
        reset = 1'b1;
        x = 10'd6;
        tick;
        chk("rst_mid", int'(draw), 0);
        reset = 1'b0;
        x = 10'd7;
        tick;
        chk("rst_after", int'(draw), 0);
        chk("rst_fill2", int'(fill), 0);
        frame;
        scan(240, 0, H - 1);
        chk("rst_nofill", cnt(1, 0, 639), 0);

        // 1500 samples wrap the 1024-deep buffer; window = samples 860..1499.
        for (int i = 0; i < 1500; i++) push(0, (i < 1000) ? 0 : ((i < 1300) ? 255 : 128), 1);
        chk("wrap_fill0", int'(fill[9:0]), 640);
        chk("wrap_fill1", int'(fill[19:10]), 0);
        frame;
        scan(239, 0, H - 1);
        chk("wrap_r239", cnt(0, 0, 639), 141);
        scan(1, 0, H - 1);
        chk("wrap_r1", cnt(0, 0, 639), 301);
        scan(119, 0, H - 1);
        chk("wrap_r119", cnt(0, 0, 639), 201);
        scan(121, 0, H - 1);
        chk("wrap_r121", cnt(0, 0, 639), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
